// File: rtl/pong_playfield.sv
// pong_playfield
//   Game core for the pong display path. Holds ball position/velocity, both
//   bat positions and scores, and sequences SERVE -> PLAY -> POINT ->
//   (SERVE | GAME_OVER). Every piece of game state advances only on clock
//   edges where frame_tick is high. The pixel flags are recomputed on every
//   clock from the beam position and are registered, so they arrive one
//   clock after hpos/vpos.
//
// Optional feature (compile-time macro):
//   PONG_AI_EN  - when defined, right_pad is ignored and the right bat
//                 steers itself 1 px per frame toward the ball centre.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   frame_tick   one-cycle pulse per frame (start of vblank)
//   hpos, vpos   beam position (9 bits each)
//   left_pad     requested left bat top y
//   right_pad    requested right bat top y (unused with PONG_AI_EN)
//   start        level; restarts the game from GAME_OVER on a tick
//   ball_on      beam is inside the ball (registered)
//   bats_on      beam is inside either bat (registered)
//   left_score   left player score
//   right_score  right player score
//   game_over    high while in GAME_OVER
module pong_playfield #(
  parameter int H_ACTIVE     = 256,
  parameter int V_ACTIVE     = 240,
  parameter int BAT_H        = 16,
  parameter int BAT_W        = 4,
  parameter int BALL_SZ      = 4,
  parameter int LEFT_BAT_X   = 16,
  parameter int RIGHT_BAT_X  = 236,
  parameter int SCORE_MAX    = 11,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic [7:0] left_pad,
  input  logic [7:0] right_pad,
  input  logic       start,
  output logic       ball_on,
  output logic       bats_on,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  // All geometry is held as 10-bit signed so "next position" can go
  // negative without wrapping.
  localparam logic signed [9:0] C_H_ACTIVE  = 10'(H_ACTIVE);
  localparam logic signed [9:0] C_V_ACTIVE  = 10'(V_ACTIVE);
  localparam logic signed [9:0] C_BALL_SZ   = 10'(BALL_SZ);
  localparam logic signed [9:0] C_BALL_HALF = 10'(BALL_SZ / 2);
  localparam logic signed [9:0] C_BAT_H     = 10'(BAT_H);
  localparam logic signed [9:0] C_BAT_HALF  = 10'(BAT_H / 2);
  localparam logic signed [9:0] C_LBAT_X    = 10'(LEFT_BAT_X);
  localparam logic signed [9:0] C_LBAT_XE   = 10'(LEFT_BAT_X + BAT_W);
  localparam logic signed [9:0] C_RBAT_X    = 10'(RIGHT_BAT_X);
  localparam logic signed [9:0] C_RBAT_XE   = 10'(RIGHT_BAT_X + BAT_W);
  localparam logic signed [9:0] C_X_MAX     = 10'(H_ACTIVE - BALL_SZ);
  localparam logic signed [9:0] C_Y_MAX     = 10'(V_ACTIVE - BALL_SZ);
  localparam logic signed [9:0] C_BAT_Y_MAX = 10'(V_ACTIVE - BAT_H);
  localparam logic signed [9:0] C_BALL_X0   = 10'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic signed [9:0] C_BALL_Y0   = 10'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic signed [9:0] C_BAT_Y0    = 10'((V_ACTIVE - BAT_H) / 2);
  localparam logic [3:0]        C_SCORE_MAX = 4'(SCORE_MAX);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic signed [9:0] ball_x_reg, ball_x_next;
  logic signed [9:0] ball_y_reg, ball_y_next;
  logic              dx_pos_reg, dx_pos_next;   // 1: dx=+1, 0: dx=-1
  logic              dy_pos_reg, dy_pos_next;   // 1: dy=+1, 0: dy=-1
  logic signed [9:0] lbat_y_reg, lbat_y_next;
  logic signed [9:0] rbat_y_reg, rbat_y_next;
  logic [3:0]        lscore_reg, lscore_next;
  logic [3:0]        rscore_reg, rscore_next;
  logic              right_scored_reg, right_scored_next;
  logic              ball_on_reg, bats_on_reg;

  // Requested pad positions saturate at the lowest legal bat top.
  function automatic logic signed [9:0] clamp_pad(input logic [7:0] pad);
    logic signed [9:0] p;
    p = {2'b00, pad};
    return (p > C_BAT_Y_MAX) ? C_BAT_Y_MAX : p;
  endfunction

  // ---------------------------------------------------------------------
  // PLAY-step datapath: next position, wall bounce, bat hits, misses
  // ---------------------------------------------------------------------
  logic signed [9:0] step_x, step_y, nx, ny, yw;
  logic              wall_top, wall_bot, dy_wall;
  logic              hit_l, hit_r, miss_l, miss_r;
  logic              above_l, above_r;

  assign step_x   = dx_pos_reg ? 10'sd1 : -10'sd1;
  assign step_y   = dy_pos_reg ? 10'sd1 : -10'sd1;
  assign nx       = ball_x_reg + step_x;
  assign ny       = ball_y_reg + step_y;
  assign wall_top = (ny <= 10'sd0);
  assign wall_bot = (ny >= C_Y_MAX);
  assign yw       = wall_top ? 10'sd0 : (wall_bot ? C_Y_MAX : ny);
  assign dy_wall  = wall_top ? 1'b1 : (wall_bot ? 1'b0 : dy_pos_reg);

  // Hit tests use the wall-corrected y so a corner bounce off a bat works.
  assign hit_l = !dx_pos_reg
              && (nx < C_LBAT_XE) && (nx + C_BALL_SZ > C_LBAT_X)
              && (yw < lbat_y_reg + C_BAT_H) && (yw + C_BALL_SZ > lbat_y_reg);
  assign hit_r = dx_pos_reg
              && (nx < C_RBAT_XE) && (nx + C_BALL_SZ > C_RBAT_X)
              && (yw < rbat_y_reg + C_BAT_H) && (yw + C_BALL_SZ > rbat_y_reg);
  assign miss_l  = (nx <= 10'sd0);
  assign miss_r  = (nx >= C_X_MAX);
  assign above_l = (yw + C_BALL_HALF) < (lbat_y_reg + C_BAT_HALF);
  assign above_r = (yw + C_BALL_HALF) < (rbat_y_reg + C_BAT_HALF);

`ifdef PONG_AI_EN
  logic signed [9:0] ball_c, rbat_c;
  logic              unused_right_pad;
  assign ball_c           = ball_y_reg + C_BALL_HALF;
  assign rbat_c           = rbat_y_reg + C_BAT_HALF;
  assign unused_right_pad = ^right_pad;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    ball_x_next       = ball_x_reg;
    ball_y_next       = ball_y_reg;
    dx_pos_next       = dx_pos_reg;
    dy_pos_next       = dy_pos_reg;
    lbat_y_next       = lbat_y_reg;
    rbat_y_next       = rbat_y_reg;
    lscore_next       = lscore_reg;
    rscore_next       = rscore_reg;
    right_scored_next = right_scored_reg;

    if (frame_tick) begin
      lbat_y_next = clamp_pad(left_pad);
`ifdef PONG_AI_EN
      if (state_reg != ST_OVER) begin
        if ((ball_c > rbat_c) && (rbat_y_reg < C_BAT_Y_MAX))
          rbat_y_next = rbat_y_reg + 10'sd1;
        else if ((ball_c < rbat_c) && (rbat_y_reg > 10'sd0))
          rbat_y_next = rbat_y_reg - 10'sd1;
      end
`else
      rbat_y_next = clamp_pad(right_pad);
`endif

      case (state_reg)
        ST_SERVE: begin
          ball_x_next = C_BALL_X0;
          ball_y_next = C_BALL_Y0;
          if (cnt_reg == C_CNT_LAST)
            state_next = ST_PLAY;
          else
            cnt_next = cnt_reg + CNT_W'(1);
        end

        ST_PLAY: begin
          ball_x_next = nx;
          ball_y_next = yw;
          dy_pos_next = dy_wall;
          // A hit wins over a miss decided on the same frame.
          if (hit_l) begin
            ball_x_next = C_LBAT_XE;
            dx_pos_next = 1'b1;
            dy_pos_next = !above_l;
          end else if (hit_r) begin
            ball_x_next = C_RBAT_X - C_BALL_SZ;
            dx_pos_next = 1'b0;
            dy_pos_next = !above_r;
          end else if (miss_l) begin
            right_scored_next = 1'b1;
            state_next        = ST_POINT;
          end else if (miss_r) begin
            right_scored_next = 1'b0;
            state_next        = ST_POINT;
          end
        end

        ST_POINT: begin
          // Next serve heads toward whoever just lost the point.
          dx_pos_next = !right_scored_reg;
          if (right_scored_reg) begin
            rscore_next = rscore_reg + 4'd1;
          end else begin
            lscore_next = lscore_reg + 4'd1;
          end
          if ((right_scored_reg ? rscore_reg : lscore_reg) + 4'd1 == C_SCORE_MAX) begin
            state_next = ST_OVER;
          end else begin
            state_next  = ST_SERVE;
            cnt_next    = '0;
            ball_x_next = C_BALL_X0;
            ball_y_next = C_BALL_Y0;
          end
        end

        ST_OVER: begin
          if (start) begin
            state_next  = ST_SERVE;
            cnt_next    = '0;
            lscore_next = 4'd0;
            rscore_next = 4'd0;
            ball_x_next = C_BALL_X0;
            ball_y_next = C_BALL_Y0;
          end
        end

        default: state_next = ST_SERVE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Beam compare (registered)
  // ---------------------------------------------------------------------
  logic signed [9:0] h_s, v_s;
  logic              in_active, in_ball, in_lbat, in_rbat;

  assign h_s       = {1'b0, hpos};
  assign v_s       = {1'b0, vpos};
  assign in_active = (h_s < C_H_ACTIVE) && (v_s < C_V_ACTIVE);
  assign in_ball   = (h_s >= ball_x_reg) && (h_s < ball_x_reg + C_BALL_SZ)
                  && (v_s >= ball_y_reg) && (v_s < ball_y_reg + C_BALL_SZ);
  assign in_lbat   = (h_s >= C_LBAT_X) && (h_s < C_LBAT_XE)
                  && (v_s >= lbat_y_reg) && (v_s < lbat_y_reg + C_BAT_H);
  assign in_rbat   = (h_s >= C_RBAT_X) && (h_s < C_RBAT_XE)
                  && (v_s >= rbat_y_reg) && (v_s < rbat_y_reg + C_BAT_H);

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_SERVE;
      cnt_reg          <= '0;
      ball_x_reg       <= C_BALL_X0;
      ball_y_reg       <= C_BALL_Y0;
      dx_pos_reg       <= 1'b1;
      dy_pos_reg       <= 1'b1;
      lbat_y_reg       <= C_BAT_Y0;
      rbat_y_reg       <= C_BAT_Y0;
      lscore_reg       <= 4'd0;
      rscore_reg       <= 4'd0;
      right_scored_reg <= 1'b0;
      ball_on_reg      <= 1'b0;
      bats_on_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      ball_x_reg       <= ball_x_next;
      ball_y_reg       <= ball_y_next;
      dx_pos_reg       <= dx_pos_next;
      dy_pos_reg       <= dy_pos_next;
      lbat_y_reg       <= lbat_y_next;
      rbat_y_reg       <= rbat_y_next;
      lscore_reg       <= lscore_next;
      rscore_reg       <= rscore_next;
      right_scored_reg <= right_scored_next;
      ball_on_reg      <= in_active && in_ball && (state_reg != ST_OVER);
      bats_on_reg      <= in_lbat || in_rbat;
    end
  end

  assign ball_on     = ball_on_reg;
  assign bats_on     = bats_on_reg;
  assign left_score  = lscore_reg;
  assign right_score = rscore_reg;
  assign game_over   = (state_reg == ST_OVER);

endmodule

// File: tb/tb_pong_playfield.sv
// tb_pong_playfield
//   Randomised bench for pong_playfield. A frame-level game model (plain
//   integer arithmetic over the game rules) tracks ball, bats, scores and
//   phase; after every frame tick the scores and game_over are compared,
//   and the registered pixel flags are probed at random, near-ball and
//   near-bat beam positions. Honours PONG_AI_EN the same way as the design.
module tb_pong_playfield;

  localparam int H_ACTIVE     = 256;
  localparam int V_ACTIVE     = 240;
  localparam int BAT_H        = 16;
  localparam int BAT_W        = 4;
  localparam int BALL_SZ      = 4;
  localparam int LEFT_BAT_X   = 16;
  localparam int RIGHT_BAT_X  = 236;
  localparam int SCORE_MAX    = 11;
  localparam int SERVE_FRAMES = 60;
  localparam int N_TICKS      = 6000;

  localparam int P_SERVE = 0, P_PLAY = 1, P_POINT = 2, P_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic [7:0] left_pad = 8'd112;
  logic [7:0] right_pad = 8'd112;
  logic       start = 1'b0;
  logic       ball_on, bats_on, game_over;
  logic [3:0] left_score, right_score;

  pong_playfield dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hpos       (hpos),
    .vpos       (vpos),
    .left_pad   (left_pad),
    .right_pad  (right_pad),
    .start      (start),
    .ball_on    (ball_on),
    .bats_on    (bats_on),
    .left_score (left_score),
    .right_score(right_score),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Game model
  // ------------------------------------------------------------------
  int m_bx, m_by, m_dx, m_dy, m_lb, m_rb, m_ls, m_rs, m_phase, m_serve_ticks;
  bit m_right_scored;

  task automatic model_reset();
    m_bx = (H_ACTIVE - BALL_SZ) / 2;
    m_by = (V_ACTIVE - BALL_SZ) / 2;
    m_dx = 1;
    m_dy = 1;
    m_lb = (V_ACTIVE - BAT_H) / 2;
    m_rb = (V_ACTIVE - BAT_H) / 2;
    m_ls = 0;
    m_rs = 0;
    m_phase = P_SERVE;
    m_serve_ticks = 0;
    m_right_scored = 0;
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit ranges_overlap(input int a0, input int alen, input int b0, input int blen);
    return (a0 < b0 + blen) && (b0 < a0 + alen);
  endfunction

  task automatic centre_ball();
    m_bx = (H_ACTIVE - BALL_SZ) / 2;
    m_by = (V_ACTIVE - BALL_SZ) / 2;
  endtask

  task automatic model_tick(input int lp, input int rp, input bit strt);
    int new_lb, new_rb, x, y;
    new_lb = (lp > V_ACTIVE - BAT_H) ? V_ACTIVE - BAT_H : lp;
`ifdef PONG_AI_EN
    new_rb = m_rb;
    if (m_phase != P_OVER) begin
      if (m_by + BALL_SZ / 2 > m_rb + BAT_H / 2) new_rb = m_rb + 1;
      else if (m_by + BALL_SZ / 2 < m_rb + BAT_H / 2) new_rb = m_rb - 1;
      new_rb = lim(new_rb, 0, V_ACTIVE - BAT_H);
    end
`else
    new_rb = (rp > V_ACTIVE - BAT_H) ? V_ACTIVE - BAT_H : rp;
`endif
    case (m_phase)
      P_SERVE: begin
        centre_ball();
        m_serve_ticks++;
        if (m_serve_ticks == SERVE_FRAMES) m_phase = P_PLAY;
      end
      P_PLAY: begin
        x = m_bx + m_dx;
        y = m_by + m_dy;
        if (y <= 0) begin y = 0; m_dy = 1; end
        else if (y >= V_ACTIVE - BALL_SZ) begin y = V_ACTIVE - BALL_SZ; m_dy = -1; end
        if (m_dx < 0 && ranges_overlap(x, BALL_SZ, LEFT_BAT_X, BAT_W)
            && ranges_overlap(y, BALL_SZ, m_lb, BAT_H)) begin
          x = LEFT_BAT_X + BAT_W;
          m_dx = 1;
          m_dy = (2 * y + BALL_SZ < 2 * m_lb + BAT_H) ? -1 : 1;
        end else if (m_dx > 0 && ranges_overlap(x, BALL_SZ, RIGHT_BAT_X, BAT_W)
            && ranges_overlap(y, BALL_SZ, m_rb, BAT_H)) begin
          x = RIGHT_BAT_X - BALL_SZ;
          m_dx = -1;
          m_dy = (2 * y + BALL_SZ < 2 * m_rb + BAT_H) ? -1 : 1;
        end else if (x <= 0) begin
          m_right_scored = 1;
          m_phase = P_POINT;
        end else if (x >= H_ACTIVE - BALL_SZ) begin
          m_right_scored = 0;
          m_phase = P_POINT;
        end
        m_bx = x;
        m_by = y;
      end
      P_POINT: begin
        if (m_right_scored) m_rs++; else m_ls++;
        m_dx = m_right_scored ? -1 : 1;
        if (m_rs == SCORE_MAX || m_ls == SCORE_MAX) begin
          m_phase = P_OVER;
        end else begin
          m_phase = P_SERVE;
          m_serve_ticks = 0;
          centre_ball();
        end
      end
      default: begin
        if (strt) begin
          m_ls = 0;
          m_rs = 0;
          m_phase = P_SERVE;
          m_serve_ticks = 0;
          centre_ball();
        end
      end
    endcase
    m_lb = new_lb;
    m_rb = new_rb;
  endtask

  function automatic int exp_ball(input int h, input int v);
    return int'(m_phase != P_OVER && h < H_ACTIVE && v < V_ACTIVE
                && h >= m_bx && h < m_bx + BALL_SZ && v >= m_by && v < m_by + BALL_SZ);
  endfunction

  function automatic int exp_bats(input int h, input int v);
    return int'((h >= LEFT_BAT_X && h < LEFT_BAT_X + BAT_W && v >= m_lb && v < m_lb + BAT_H)
             || (h >= RIGHT_BAT_X && h < RIGHT_BAT_X + BAT_W && v >= m_rb && v < m_rb + BAT_H));
  endfunction

  // ------------------------------------------------------------------
  // Drivers (entered and left at a falling edge)
  // ------------------------------------------------------------------
  int tick_no = 0;

  task automatic do_tick(input int lp, input int rp, input bit strt);
    left_pad   = 8'(lp);
    right_pad  = 8'(rp);
    start      = strt;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(lp, rp, strt);
    tick_no++;
    $display("tick %0d phase=%0d ball=(%0d,%0d) d=(%0d,%0d) bats=%0d/%0d score=%0d-%0d",
             tick_no, m_phase, m_bx, m_by, m_dx, m_dy, m_lb, m_rb, m_ls, m_rs);
    check_val("left_score", int'(left_score), m_ls);
    check_val("right_score", int'(right_score), m_rs);
    check_val("game_over", int'(game_over), int'(m_phase == P_OVER));
  endtask

  task automatic probe(input int h, input int v, output int got_ball);
    h = lim(h, 0, 511);
    v = lim(v, 0, 511);
    hpos = 9'(h);
    vpos = 9'(v);
    @(negedge clk);
    got_ball = int'(ball_on);
    check_val("ball_on", int'(ball_on), exp_ball(h, v));
    check_val("bats_on", int'(bats_on), exp_bats(h, v));
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    int  got, lp, rp, loff, roff;
    bit  ltrack, rtrack, strt;

    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_left_score", int'(left_score), 0);
    check_val("rst_right_score", int'(right_score), 0);
    check_val("rst_game_over", int'(game_over), 0);
    check_val("rst_ball_on", int'(ball_on), 0);
    check_val("rst_bats_on", int'(bats_on), 0);
    reset = 1'b1;
    @(negedge clk);

    // Serve phase: 60 ticks parked at centre, first PLAY tick moves +1,+1.
    repeat (SERVE_FRAMES) do_tick(112, 112, 1'b0);
    probe(126, 118, got);
    check_val("serve_centre", got, 1);
    do_tick(112, 112, 1'b0);
    probe(127, 119, got);
    check_val("first_move_new", got, 1);
    probe(126, 118, got);
    check_val("first_move_old", got, 0);
    probe(LEFT_BAT_X, 112, got);
    probe(RIGHT_BAT_X + BAT_W, 112, got);

    ltrack = 0; rtrack = 1; loff = 4; roff = 4;
    for (int i = 0; i < N_TICKS; i++) begin
      if (i == N_TICKS / 2) begin
        // Asynchronous reset in the middle of a frame.
        #2 reset = 1'b0;
        #1;
        check_val("mid_rst_left_score", int'(left_score), 0);
        check_val("mid_rst_right_score", int'(right_score), 0);
        check_val("mid_rst_game_over", int'(game_over), 0);
        check_val("mid_rst_ball_on", int'(ball_on), 0);
        check_val("mid_rst_bats_on", int'(bats_on), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
      end

      if (m_phase == P_SERVE) begin
        ltrack = ($urandom_range(0, 3) == 0);
        rtrack = ($urandom_range(0, 3) != 0);
        loff   = $urandom_range(0, 26) - 6;
        roff   = $urandom_range(0, 26) - 6;
      end
      lp = ltrack ? lim(m_by - loff, 0, 255) : int'($urandom_range(0, 255));
      rp = rtrack ? lim(m_by - roff, 0, 255) : int'($urandom_range(0, 255));
      if (m_phase == P_OVER) strt = ($urandom_range(0, 7) == 0);
      else                   strt = ($urandom_range(0, 3) == 0);
      do_tick(lp, rp, strt);

      probe(int'($urandom_range(0, 511)), int'($urandom_range(0, 300)), got);
      probe(m_bx + int'($urandom_range(0, 7)) - 2, m_by + int'($urandom_range(0, 7)) - 2, got);
      if ($urandom_range(0, 1) == 0)
        probe(LEFT_BAT_X - 1 + int'($urandom_range(0, 5)), m_lb - 2 + int'($urandom_range(0, 19)), got);
      else
        probe(RIGHT_BAT_X - 1 + int'($urandom_range(0, 5)), m_rb - 2 + int'($urandom_range(0, 19)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
